// File: rtl/ref_clk_gen_pkg.sv
// Shared constants and sizing helper for the reference-clock generator.
// The default periods describe a 32.768 kHz reference derived from a 100 MHz system clock.
package ref_clk_gen_pkg;

    localparam int unsigned REF_CLK_PERIOD = 30517;
    localparam int unsigned SYS_CLK_PERIOD = 10;

    // The width leaves headroom for acc + 2*src_period,
    // so the sum can be compared before it wraps.
    function automatic int unsigned acc_width(input int unsigned clk_period,
                                              input int unsigned src_period);
        return $clog2(clk_period + 2 * src_period) + 1;
    endfunction

endpackage

// File: rtl/ref_clk_phase_acc.sv
// Fractional phase accumulator: each enabled cycle adds 2*SRC_PERIOD to the phase.
// It requests one output toggle each time the phase passes CLK_PERIOD.
module ref_clk_phase_acc
    import ref_clk_gen_pkg::*;
#(
    parameter int unsigned CLK_PERIOD = REF_CLK_PERIOD,
    parameter int unsigned SRC_PERIOD = SYS_CLK_PERIOD,
    parameter int unsigned ACC_W      = acc_width(CLK_PERIOD, SRC_PERIOD)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic toggle_o
);

    localparam logic [ACC_W-1:0] STEP   = ACC_W'(2 * SRC_PERIOD);
    localparam logic [ACC_W-1:0] PERIOD = ACC_W'(CLK_PERIOD);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic             wrap;

    // NOTE: every always_comb output is assigned on every path; otherwise a latch is inferred.
    always_comb begin
        sum  = acc + STEP;
        wrap = (sum >= PERIOD);
    end

    // NOTE: sequential state uses non-blocking assignments, so all flops update together at the edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc <= '0;
        end else if (en_i) begin
            acc <= wrap ? (sum - PERIOD) : sum;
        end
    end

    assign toggle_o = en_i & wrap;

endmodule

// File: rtl/ref_clk_gen.sv
// Reference-clock generator top: the registered clk_o, the edge strobes and the rising-edge counter.
// All outputs come straight from flops; the phase accumulator only says when to toggle.
module ref_clk_gen
    import ref_clk_gen_pkg::*;
#(
    parameter int unsigned CLK_PERIOD = REF_CLK_PERIOD,
    parameter int unsigned SRC_PERIOD = SYS_CLK_PERIOD,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic             clk_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic [CNT_W-1:0] period_cnt_o
);

    // Requiring CLK_PERIOD >= 2*SRC_PERIOD ensures clk_o toggles at most once per clk_i cycle.
    if (CLK_PERIOD == 0 || SRC_PERIOD == 0) begin : g_zero_period
        $error("ref_clk_gen: CLK_PERIOD and SRC_PERIOD must be non-zero");
    end
    if (CLK_PERIOD < 2 * SRC_PERIOD) begin : g_period_too_small
        $error("ref_clk_gen: CLK_PERIOD must be at least 2*SRC_PERIOD");
    end

    logic toggle;

    ref_clk_phase_acc #(
        .CLK_PERIOD (CLK_PERIOD),
        .SRC_PERIOD (SRC_PERIOD)
    ) u_phase_acc (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en_i     (en_i),
        .toggle_o (toggle)
    );

    // Each strobe is computed from the old level, so it is high exactly in the cycle
    // clk_o first shows the new level.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_o        <= 1'b0;
            rise_o       <= 1'b0;
            fall_o       <= 1'b0;
            period_cnt_o <= '0;
        end else begin
            rise_o <= 1'b0;
            fall_o <= 1'b0;
            if (toggle) begin
                clk_o  <= ~clk_o;
                rise_o <= ~clk_o;
                fall_o <= clk_o;
                if (!clk_o) begin
                    period_cnt_o <= period_cnt_o + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ref_clk_gen.sv
// Directed testbench for ref_clk_gen.
// Each DUT instance covers one parameter set; expected values are computed by hand.
module tb_ref_clk_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst40 = 1'b1, en40 = 1'b1;
    logic rst30 = 1'b1, en30 = 1'b1;
    logic rst20 = 1'b1, en20 = 1'b1;
    logic rstw  = 1'b1, enw  = 1'b1;
    logic rstd  = 1'b1, end_ = 1'b1;

    logic        c40, r40, f40;
    logic [31:0] n40;
    logic        c30, r30, f30;
    logic [31:0] n30;
    logic        c20, r20, f20;
    logic [31:0] n20;
    logic        cw, rw, fw;
    logic [3:0]  nw;
    logic        cd, rd, fd;
    logic [31:0] nd;

    ref_clk_gen #(.CLK_PERIOD(40), .SRC_PERIOD(10)) d40 (
        .clk_i(clk), .rst_i(rst40), .en_i(en40),
        .clk_o(c40), .rise_o(r40), .fall_o(f40), .period_cnt_o(n40));

    ref_clk_gen #(.CLK_PERIOD(30), .SRC_PERIOD(10)) d30 (
        .clk_i(clk), .rst_i(rst30), .en_i(en30),
        .clk_o(c30), .rise_o(r30), .fall_o(f30), .period_cnt_o(n30));

    ref_clk_gen #(.CLK_PERIOD(20), .SRC_PERIOD(10)) d20 (
        .clk_i(clk), .rst_i(rst20), .en_i(en20),
        .clk_o(c20), .rise_o(r20), .fall_o(f20), .period_cnt_o(n20));

    ref_clk_gen #(.CLK_PERIOD(40), .SRC_PERIOD(10), .CNT_W(4)) dwrap (
        .clk_i(clk), .rst_i(rstw), .en_i(enw),
        .clk_o(cw), .rise_o(rw), .fall_o(fw), .period_cnt_o(nw));

    ref_clk_gen ddef (
        .clk_i(clk), .rst_i(rstd), .en_i(end_),
        .clk_o(cd), .rise_o(rd), .fall_o(fd), .period_cnt_o(nd));

    int errors = 0;
    int checks = 0;

    // Expected per-cycle values after each enabled edge.
    int clk40_exp[10]  = '{0, 1, 1, 0, 0, 1, 1, 0, 0, 1};
    int rise40_exp[10] = '{0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
    int fall40_exp[10] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0};
    int clk30_exp[9]   = '{0, 1, 0, 0, 1, 0, 0, 1, 0};
    int rise30_exp[9]  = '{0, 1, 0, 0, 1, 0, 0, 1, 0};
    int fall30_exp[9]  = '{0, 0, 1, 0, 0, 1, 0, 0, 1};
    int clk20_exp[4]   = '{1, 0, 1, 0};
    int cnt20_exp[4]   = '{1, 1, 2, 2};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after each rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int rises;
        int falls;
        int first_rise;

        // Hold reset for 3 cycles with enable high.
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("rst_clk40", c40, 0);
            check("rst_rise40", r40, 0);
            check("rst_fall40", f40, 0);
            check("rst_cnt40", n40, 0);
            check("rst_clk30", c30, 0);
        end

        // CLK_PERIOD=40: toggles every 2 enabled cycles.
        rst40 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check($sformatf("p40_clk_c%0d", i + 1), c40, clk40_exp[i]);
            check($sformatf("p40_rise_c%0d", i + 1), r40, rise40_exp[i]);
            check($sformatf("p40_fall_c%0d", i + 1), f40, fall40_exp[i]);
        end
        check("p40_cnt_after10", n40, 3);

        // Enable gating while clk_o is high and the phase is one step short of a fall.
        step(1);
        check("gate_pre_clk", c40, 1);
        check("gate_pre_fall", f40, 0);
        en40 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("gate_off_clk", c40, 1);
            check("gate_off_rise", r40, 0);
            check("gate_off_fall", f40, 0);
            check("gate_off_cnt", n40, 3);
        end
        en40 = 1'b1;
        step(1);
        check("gate_resume_fall", f40, 1);
        check("gate_resume_clk", c40, 0);
        check("gate_resume_cnt", n40, 3);

        // CLK_PERIOD=30: toggles at cycles 2,3,5,6,8,9.
        rst30 = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step(1);
            check($sformatf("p30_clk_c%0d", i + 1), c30, clk30_exp[i]);
            check($sformatf("p30_rise_c%0d", i + 1), r30, rise30_exp[i]);
            check($sformatf("p30_fall_c%0d", i + 1), f30, fall30_exp[i]);
        end
        check("p30_cnt_after9", n30, 3);

        // CLK_PERIOD == 2*SRC_PERIOD: clk_o toggles every cycle.
        rst20 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check($sformatf("p20_clk_c%0d", i + 1), c20, clk20_exp[i]);
            check($sformatf("p20_cnt_c%0d", i + 1), n20, cnt20_exp[i]);
        end

        // 4-bit counter wrap: rises at cycles 2+4k; the 15th rise is at 58, the 16th at 62, the 17th at 66.
        rstw = 1'b0;
        for (int c = 1; c <= 66; c++) begin
            step(1);
            if (c == 58) check("wrap_cnt_15", nw, 15);
            if (c == 62) check("wrap_cnt_0", nw, 0);
            if (c == 66) check("wrap_cnt_1", nw, 1);
        end
        check("wrap_clk_high", cw, 1);
        step(1);
        rstw = 1'b1;
        step(1);
        check("midrst_clk", cw, 0);
        check("midrst_fall", fw, 0);
        check("midrst_rise", rw, 0);
        check("midrst_cnt", nw, 0);

        // Default parameters: 30517 enabled cycles give exactly 10 full periods.
        rstd       = 1'b0;
        rises      = 0;
        falls      = 0;
        first_rise = 0;
        for (int c = 1; c <= 30517; c++) begin
            step(1);
            if (rd) begin
                rises++;
                if (first_rise == 0) first_rise = c;
            end
            if (fd) falls++;
        end
        check("def_first_rise", first_rise, 1526);
        check("def_rises", rises, 10);
        check("def_falls", falls, 10);
        check("def_clk", cd, 0);
        check("def_acc", ddef.u_phase_acc.acc, 0);
        check("def_cnt", nd, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
